// File: rtl/s_spi_ctrl.sv
// SPI mode-0 slave byte engine. The SPI pins are synchronised into the clk domain.
// Each frame shifts one DATA_WIDTH word in from the master and one word out to it.
module s_spi_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic                  MISO,
    output logic [DATA_WIDTH-1:0] data_from_master,
    input  logic [DATA_WIDTH-1:0] data_to_master,
    output logic                  receiveing,
    output logic                  transmitting,
    output logic                  dbg
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_TAIL} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d;
    logic                   sclk_rise, sclk_fall, ss_act, mosi_s;
    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [DATA_WIDTH-1:0]  rx_sr, tx_sr;
    logic                   rx_last, load;

    // SS synchroniser resets to the inactive level so nothing starts out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
    assign ss_act    = ~ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // TAIL waits for the fall that closes the byte after the last rise.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: if (ss_act) begin
                state_nxt = ST_SHIFT;
                load      = 1'b1;
            end
            ST_SHIFT: begin
                if (!ss_act)                            state_nxt = ST_IDLE;
                else if (sclk_rise && cnt == LAST_BIT)  state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                if (!ss_act) state_nxt = ST_IDLE;
                else if (sclk_fall) begin
                    state_nxt = ST_SHIFT;
                    load      = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= '0;
            rx_sr            <= '0;
            tx_sr            <= '0;
            data_from_master <= '0;
            receiveing       <= 1'b0;
            transmitting     <= 1'b0;
            rx_last          <= 1'b0;
            dbg              <= 1'b0;
        end else if (!ss_act) begin
            cnt          <= '0;
            rx_sr        <= '0;
            receiveing   <= 1'b0;
            transmitting <= 1'b0;
            rx_last      <= 1'b0;
        end else begin
            // Low for one clk on the byte-closing fall, so back-to-back bytes show a dip.
            transmitting <= !(state == ST_TAIL && sclk_fall);
            if (load)
                tx_sr <= data_to_master;
            else if (state == ST_SHIFT && sclk_fall)
                tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};

            rx_last <= 1'b0;
            if (rx_last) receiveing <= 1'b0;
            if (state == ST_SHIFT && sclk_rise) begin
                rx_sr      <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
                receiveing <= 1'b1;
                if (cnt == LAST_BIT) begin
                    cnt              <= '0;
                    data_from_master <= {rx_sr[DATA_WIDTH-2:0], mosi_s};
                    dbg              <= ~dbg;
                    rx_last          <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign MISO = (ss_act && state != ST_IDLE) ? tx_sr[DATA_WIDTH-1] : 1'bz;
endmodule

// File: tb/tb_s_spi_ctrl.sv
// Directed bench for s_spi_ctrl: acts as an SPI mode-0 master with SCLK = clk/16.
// A table covers single frames; hand sequences cover back-to-back bytes, abort and async reset.
module tb_s_spi_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, SCLK, MOSI, SS;
    wire        MISO;
    logic [7:0] data_from_master, data_to_master;
    logic       receiveing, transmitting, dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    s_spi_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .data_from_master(data_from_master), .data_to_master(data_to_master),
        .receiveing(receiveing), .transmitting(transmitting), .dbg(dbg)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Byte-done monitor: records data_from_master as seen one clk before receiveing falls,
    // and checks that transmitting dips for exactly one clk between bytes.
    logic [7:0] rx_q[$];
    logic       prev_rcv = 1'b0, prev_tx = 1'b0;
    logic [7:0] prev_dfm = '0;
    bit         in_dip = 1'b0;
    int         dip_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_dip = 1'b0;
        end else if (!SS) begin
            if (prev_rcv && !receiveing) rx_q.push_back(prev_dfm);
            if (in_dip) begin
                if (transmitting) begin
                    check("tx_dip_len", dip_len, 1);
                    in_dip = 1'b0;
                end else dip_len++;
            end else if (prev_tx && !transmitting) begin
                in_dip  = 1'b1;
                dip_len = 1;
            end
        end
        prev_rcv = receiveing;
        prev_tx  = transmitting;
        prev_dfm = data_from_master;
    end

    task automatic half();
        repeat (8) @(negedge clk);
        #2;
    endtask

    // Master shifts nbits of mo out MSB first, reads MISO at each rise; nxt is applied
    // to data_to_master right after the first rise.
    task automatic spi_xfer(input logic [7:0] mo, input logic [7:0] nxt, input int nbits,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = mo[i];
            half();
            SCLK  = 1'b1;
            mi[i] = MISO;
            if (i == 7) data_to_master = nxt;
            half();
            SCLK = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] mo, input logic [7:0] tx, input logic [7:0] nxt,
                         output logic [7:0] mi);
        data_to_master = tx;
        SS = 1'b0;
        half();
        spi_xfer(mo, nxt, 8, mi);
        half();
        SS = 1'b1;
        half();
        half();
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_rcv"}, receiveing, 1'b0);
        check({nm, "_tx"}, transmitting, 1'b0);
        check({nm, "_miso_z"}, MISO, 1'bz);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] nxt;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    initial begin
        vec_t       vecs[4];
        logic [7:0] mi, m0, m1, m2;
        logic       exp_dbg;

        vecs[0] = '{8'hA5, 8'h5A, 8'h5A, 8'hA5, 8'h5A};
        vecs[1] = '{8'h00, 8'hFF, 8'hFE, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h81, 8'h00, 8'hFF, 8'h81};
        vecs[3] = '{8'h96, 8'h00, 8'hFF, 8'h96, 8'h00};

        rst_n = 1'b0; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; data_to_master = '0;
        exp_dbg = 1'b0;
        #3;
        check("rst_dfm", data_from_master, 8'h00);
        check("rst_dbg", dbg, 1'b0);
        check_idle("rst");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // SCLK activity with SS high must be ignored.
        spi_xfer(8'hFF, 8'h00, 8, mi);
        half();
        check("ssoff_dfm", data_from_master, 8'h00);
        check("ssoff_dbg", dbg, 1'b0);
        check("ssoff_q", rx_q.size(), 0);
        check_idle("ssoff");

        for (int v = 0; v < 4; v++) begin
            frame(vecs[v].mosi, vecs[v].tx, vecs[v].nxt, mi);
            exp_dbg = ~exp_dbg;
            check("vec_q_size", rx_q.size(), 1);
            if (rx_q.size() > 0) check("vec_dfm_pre_fall", rx_q.pop_front(), vecs[v].exp_rx);
            check("vec_dfm", data_from_master, vecs[v].exp_rx);
            check("vec_miso_byte", mi, vecs[v].exp_miso);
            check("vec_dbg", dbg, exp_dbg);
            check_idle("vec");
        end

        // Three bytes under one SS; each byte start samples the updated data_to_master.
        data_to_master = 8'h11;
        SS = 1'b0;
        half();
        spi_xfer(8'h01, 8'h22, 8, m0);
        spi_xfer(8'h02, 8'h33, 8, m1);
        spi_xfer(8'h03, 8'h44, 8, m2);
        half();
        SS = 1'b1;
        half(); half();
        exp_dbg = ~exp_dbg; exp_dbg = ~exp_dbg; exp_dbg = ~exp_dbg;
        check("b2b_miso0", m0, 8'h11);
        check("b2b_miso1", m1, 8'h22);
        check("b2b_miso2", m2, 8'h33);
        check("b2b_q_size", rx_q.size(), 3);
        for (int k = 1; k <= 3; k++)
            if (rx_q.size() > 0) check("b2b_rx", rx_q.pop_front(), k);
        check("b2b_dfm", data_from_master, 8'h03);
        check("b2b_dbg", dbg, exp_dbg);
        check_idle("b2b");

        // Abort after four bits of 0xC3.
        data_to_master = 8'hAA;
        SS = 1'b0;
        half();
        spi_xfer(8'hC3, 8'hAA, 4, mi);
        half();
        SS = 1'b1;
        half(); half();
        check("abort_miso_hi", mi[7:4], 4'hA);
        check("abort_dfm", data_from_master, 8'h03);
        check("abort_dbg", dbg, exp_dbg);
        check("abort_q", rx_q.size(), 0);
        check_idle("abort");

        frame(8'h3C, 8'h0F, 8'h0F, mi);
        exp_dbg = ~exp_dbg;
        check("recov_dfm", data_from_master, 8'h3C);
        check("recov_miso", mi, 8'h0F);
        check("recov_dbg", dbg, exp_dbg);
        check("recov_q", rx_q.size(), 1);
        if (rx_q.size() > 0) check("recov_pre_fall", rx_q.pop_front(), 8'h3C);

        // Asynchronous reset mid-byte, asserted and observed between clk edges.
        data_to_master = 8'hC3;
        SS = 1'b0;
        half();
        spi_xfer(8'h5A, 8'hC3, 4, mi);
        check("mid_rcv", receiveing, 1'b1);
        check("mid_tx", transmitting, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_dfm", data_from_master, 8'h00);
        check("arst_dbg", dbg, 1'b0);
        check_idle("arst");
        exp_dbg = 1'b0;
        SS = 1'b1;
        half();
        rst_n = 1'b1;
        half();
        frame(8'h5A, 8'hC3, 8'hC3, mi);
        exp_dbg = ~exp_dbg;
        check("post_dfm", data_from_master, 8'h5A);
        check("post_miso", mi, 8'hC3);
        check("post_dbg", dbg, exp_dbg);
        check("post_q", rx_q.size(), 1);
        check_idle("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
